// File: rtl/gactx_tb_packer.sv
`default_nettype none
// ============================================================================
// Module   : gactx_tb_packer
// Purpose  : Packs narrow GACTX result beats little-endian into full-width
//            AXI4-Stream words for the AXI4 write master. The final partial
//            word of each tile is zero-padded when s_tlast arrives. An
//            optional byte counter and tile-done pulse report the traffic
//            handed to the write master.
// Ports    : aclk, areset      clock; synchronous active-high reset
//            s_tvalid/s_tready input beat handshake
//            s_tdata, s_tlast  input beat and last-beat-of-tile flag
//            m_tvalid/m_tready output word handshake
//            m_tdata, m_tlast  packed word (lane k at [k*C_IN_WIDTH +: C_IN_WIDTH])
//            byte_count        bytes handed off on the m side since reset
//            tile_done         one-cycle pulse after a tile's last word leaves
// Config   : GACTX_TB_PACKER_COUNT_EN builds byte_count / tile_done; when it
//            is undefined both outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module gactx_tb_packer #(
   parameter int C_IN_WIDTH  = 32,
   parameter int C_OUT_WIDTH = 512,
   parameter int C_CNT_WIDTH = 32
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   input  logic [C_IN_WIDTH-1:0]  s_tdata,
   input  logic                   s_tlast,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [C_OUT_WIDTH-1:0] m_tdata,
   output logic                   m_tlast,
   output logic [C_CNT_WIDTH-1:0] byte_count,
   output logic                   tile_done
);

   localparam int R     = C_OUT_WIDTH / C_IN_WIDTH;
   localparam int IDX_W = (R > 1) ? $clog2(R) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(R - 1);

   logic [C_OUT_WIDTH-1:0] acc;
   logic [C_OUT_WIDTH-1:0] merged;
   logic [IDX_W-1:0]       idx;
   logic                   accept;
   logic                   complete;
   logic                   handshake;

   // Ready is a function of the output register only, never of s_tvalid,
   // so a stalled output word freezes the accumulator.
   assign s_tready  = ~areset & (~m_tvalid | m_tready);
   assign accept    = s_tvalid & s_tready;
   assign complete  = s_tlast | (idx == IDX_LAST);
   assign handshake = m_tvalid & m_tready;

   // Accumulator with the current beat dropped into lane idx. Used both to
   // update acc on a non-completing beat and as the outgoing word on a
   // completing one; lanes above idx are still zero from the last clear.
   always_comb begin
      merged = acc;
      for (int k = 0; k < R; k++) begin
         if (idx == IDX_W'(k)) begin
            merged[k*C_IN_WIDTH +: C_IN_WIDTH] = s_tdata;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         acc      <= '0;
         idx      <= '0;
         m_tdata  <= '0;
         m_tlast  <= 1'b0;
         m_tvalid <= 1'b0;
      end else begin
         if (accept && complete) begin
            // A load wins over a simultaneous handshake: the new word
            // replaces the departing one with no bubble.
            m_tdata  <= merged;
            m_tlast  <= s_tlast;
            m_tvalid <= 1'b1;
            acc      <= '0;
            idx      <= '0;
         end else begin
            if (accept) begin
               acc <= merged;
               idx <= idx + IDX_W'(1);
            end
            if (handshake) begin
               m_tvalid <= 1'b0;
               m_tlast  <= 1'b0;
            end
         end
      end
   end

`ifdef GACTX_TB_PACKER_COUNT_EN
   localparam logic [C_CNT_WIDTH-1:0] WORD_BYTES = C_CNT_WIDTH'(C_OUT_WIDTH / 8);

   // Counter wraps modulo 2^C_CNT_WIDTH by plain overflow.
   always_ff @(posedge aclk) begin
      if (areset) begin
         byte_count <= '0;
         tile_done  <= 1'b0;
      end else begin
         if (handshake) begin
            byte_count <= byte_count + WORD_BYTES;
         end
         tile_done <= handshake & m_tlast;
      end
   end
`else
   assign byte_count = '0;
   assign tile_done  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gactx_tb_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gactx_tb_packer
// Purpose  : Self-checking bench for gactx_tb_packer at default parameters.
//            A word-level reference model (lane queue, pending-word slot,
//            byte total) predicts every output each cycle; directed
//            scenarios add explicit checks on the packed words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gactx_tb_packer;

   localparam int W  = 32;
   localparam int OW = 512;
   localparam int R  = OW / W;
`ifdef GACTX_TB_PACKER_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          aclk;
   logic          areset;
   logic          s_tvalid;
   logic          s_tready;
   logic [W-1:0]  s_tdata;
   logic          s_tlast;
   logic          m_tvalid;
   logic          m_tready;
   logic [OW-1:0] m_tdata;
   logic          m_tlast;
   logic [31:0]   byte_count;
   logic          tile_done;

   gactx_tb_packer dut (
      .aclk       (aclk),
      .areset     (areset),
      .s_tvalid   (s_tvalid),
      .s_tready   (s_tready),
      .s_tdata    (s_tdata),
      .s_tlast    (s_tlast),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tdata    (m_tdata),
      .m_tlast    (m_tlast),
      .byte_count (byte_count),
      .tile_done  (tile_done)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [W-1:0]  lane_q[$];
   logic          pv;
   logic [OW-1:0] pw;
   logic          pl;
   logic [31:0]   bc;
   logic          td;

   // observations of words actually handed off by the DUT
   logic [OW-1:0] out_data[$];
   logic          out_last[$];
   int            pulses;

   logic [W-1:0]  beats[$];

   task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [OW-1:0] build_word();
      logic [OW-1:0] w;
      w = '0;
      for (int k = 0; k < lane_q.size(); k++) w[k*W +: W] = lane_q[k];
      return w;
   endfunction

   task automatic clear_obs();
      out_data.delete();
      out_last.delete();
      pulses = 0;
   endtask

   // One reset cycle; entered and left at a falling edge.
   task automatic rst();
      areset   = 1'b1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = '0;
      m_tready = 1'b0;
      #1;
      chk("rst_s_tready", s_tready, 0);
      @(posedge aclk);
      lane_q.delete();
      pv = 1'b0; pw = '0; pl = 1'b0; bc = '0; td = 1'b0;
      @(negedge aclk);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_byte_count", byte_count, 0);
      chk("rst_tile_done", tile_done, 0);
      areset = 1'b0;
   endtask

   // One clock cycle: drive, predict, clock, compare.
   task automatic step(input logic v, input logic [W-1:0] d, input logic l,
                       input logic rdy, output logic accepted);
      logic ex_ready, acc, hs, done;
      s_tvalid = v;
      s_tdata  = d;
      s_tlast  = l;
      m_tready = rdy;
      #1;
      ex_ready = !pv || rdy;
      chk("s_tready", s_tready, ex_ready);
      acc = v && ex_ready;
      hs  = pv && rdy;
      if (m_tvalid && m_tready) begin
         out_data.push_back(m_tdata);
         out_last.push_back(m_tlast);
      end
      @(posedge aclk);
      td = CNT_EN && hs && pl;
      if (CNT_EN && hs) bc = bc + OW / 8;
      done = 1'b0;
      if (acc) begin
         lane_q.push_back(d);
         if (lane_q.size() == R || l) begin
            pw = build_word();
            pl = l;
            pv = 1'b1;
            lane_q.delete();
            done = 1'b1;
         end
      end
      if (hs && !done) begin
         pv = 1'b0;
         pl = 1'b0;
      end
      @(negedge aclk);
      chk("m_tvalid", m_tvalid, pv);
      chk("m_tdata", m_tdata, pw);
      chk("m_tlast", m_tlast, pl);
      chk("byte_count", byte_count, bc);
      chk("tile_done", tile_done, td);
      if (tile_done) pulses++;
      accepted = acc;
   endtask

   // Send the global beats queue; mode 0: ready high, 1: ready 1,0,0,1...,
   // 2: random valid gaps and random ready.
   task automatic send(input logic last_on_end, input int mode);
      int i, cyc;
      logic a, v, r, l;
      i = 0;
      cyc = 0;
      while (i < beats.size() && cyc < 4000) begin
         v = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (mode == 0)      r = 1'b1;
         else if (mode == 1) r = (cyc % 4 == 0) || (cyc % 4 == 3);
         else                r = ($urandom_range(0, 2) != 0);
         l = v && last_on_end && (i == beats.size() - 1);
         step(v, beats[i], l, r, a);
         if (a) i++;
         cyc++;
      end
      chk("send_progress", i, beats.size());
   endtask

   task automatic drain(input int n);
      logic a;
      for (int c = 0; c < n; c++) step(1'b0, '0, 1'b0, 1'b1, a);
   endtask

   logic [OW-1:0] ew;
   int            nwords;
   int            len;

   initial begin
      areset   = 1'b1;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tlast  = 1'b0;
      m_tready = 1'b0;
      pulses   = 0;
      @(negedge aclk);

      // full word: 16 beats 0..15, tlast on the last
      clear_obs();
      rst();
      beats.delete();
      for (int k = 0; k < 16; k++) beats.push_back(W'(k));
      send(1'b1, 0);
      drain(3);
      ew = '0;
      for (int k = 0; k < 16; k++) ew[k*W +: W] = W'(k);
      chk("s1_words", out_data.size(), 1);
      if (out_data.size() >= 1) begin
         chk("s1_data", out_data[0], ew);
         chk("s1_last", out_last[0], 1);
      end
      chk("s1_bytes", byte_count, CNT_EN ? 64 : 0);
      chk("s1_pulses", pulses, CNT_EN ? 1 : 0);

      // padding: A, B, C with tlast on C
      clear_obs();
      rst();
      beats = '{32'hA, 32'hB, 32'hC};
      send(1'b1, 0);
      chk("s2_latency", m_tvalid, 1);
      drain(2);
      ew = '0;
      ew[0*W +: W] = 32'hA;
      ew[1*W +: W] = 32'hB;
      ew[2*W +: W] = 32'hC;
      chk("s2_words", out_data.size(), 1);
      if (out_data.size() >= 1) begin
         chk("s2_data", out_data[0], ew);
         chk("s2_last", out_last[0], 1);
      end

      // backpressure: 32 beats, ready toggling 1,0,0,1
      clear_obs();
      rst();
      beats.delete();
      for (int k = 0; k < 32; k++) beats.push_back(32'h1000 + W'(k));
      send(1'b1, 1);
      drain(4);
      chk("s3_words", out_data.size(), 2);
      if (out_data.size() >= 2) begin
         for (int wd = 0; wd < 2; wd++) begin
            ew = '0;
            for (int k = 0; k < 16; k++) ew[k*W +: W] = 32'h1000 + W'(wd * 16 + k);
            chk("s3_data", out_data[wd], ew);
            chk("s3_last", out_last[wd], wd == 1);
         end
      end

      // back-to-back tiles: A = 17 beats, B = 0x55
      clear_obs();
      rst();
      beats.delete();
      for (int k = 0; k < 17; k++) beats.push_back(32'h200 + W'(k));
      send(1'b1, 0);
      beats = '{32'h55};
      send(1'b1, 0);
      drain(3);
      chk("s4_words", out_data.size(), 3);
      if (out_data.size() >= 3) begin
         ew = '0;
         for (int k = 0; k < 16; k++) ew[k*W +: W] = 32'h200 + W'(k);
         chk("s4_a_full", out_data[0], ew);
         chk("s4_a_full_last", out_last[0], 0);
         ew = '0;
         ew[W-1:0] = 32'h210;
         chk("s4_a_tail", out_data[1], ew);
         chk("s4_a_tail_last", out_last[1], 1);
         ew = '0;
         ew[W-1:0] = 32'h55;
         chk("s4_b", out_data[2], ew);
         chk("s4_b_last", out_last[2], 1);
      end
      chk("s4_bytes", byte_count, CNT_EN ? 192 : 0);
      chk("s4_pulses", pulses, CNT_EN ? 2 : 0);

      // reset mid-tile: 5 beats, reset, 16 fresh beats
      clear_obs();
      rst();
      beats.delete();
      for (int k = 0; k < 5; k++) beats.push_back(32'hDEAD0000 + W'(k));
      send(1'b0, 0);
      rst();
      beats.delete();
      for (int k = 0; k < 16; k++) beats.push_back(32'h3000 + W'(k));
      send(1'b0, 0);
      drain(3);
      chk("s5_words", out_data.size(), 1);
      if (out_data.size() >= 1) begin
         chk("s5_lane0", out_data[0][W-1:0], 32'h3000);
         chk("s5_last", out_last[0], 0);
      end
      chk("s5_bytes", byte_count, CNT_EN ? 64 : 0);

      // random tiles, random valid gaps and ready
      clear_obs();
      rst();
      nwords = 0;
      for (int t = 0; t < 30; t++) begin
         len = $urandom_range(1, 40);
         nwords += (len + R - 1) / R;
         beats.delete();
         for (int k = 0; k < len; k++) beats.push_back($urandom);
         send(1'b1, 2);
      end
      drain(4);
      chk("rand_words", out_data.size(), nwords);
      chk("rand_pulses", pulses, CNT_EN ? 30 : 0);
      chk("rand_bytes", byte_count, CNT_EN ? 32'(nwords * 64) : 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gactx_tb_packer.md
# gactx_tb_packer

Width-converting packer between the GACTX traceback/tile-result producer and the AXI4 write master's AXI4-Stream slave input. It accepts narrow result beats, packs them little-endian into full-width words, zero-pads the final partial word of each tile on `s_tlast`, and presents them with AXI4-Stream valid/ready. An optional byte counter reports the bytes emitted so control logic can program the write transfer length and detect tile completion.

## Interface
- `C_IN_WIDTH`, 32: input beat width; `C_OUT_WIDTH` must be an integer multiple of it.
- `C_OUT_WIDTH`, 512: output word width; matches the write master data width.
- `C_CNT_WIDTH`, 32: byte counter width.
- Derived: `R = C_OUT_WIDTH/C_IN_WIDTH` lanes (16 at defaults); `idx` width is `$clog2(R)`.
- `aclk`  in  1  clock.
- `areset`  in  1  reset, synchronous, active-high; clock aclk.
- `s_tvalid`  in  1  input beat valid.
- `s_tready`  out  1  input beat accepted when high together with `s_tvalid`.
- `s_tdata`  in  C_IN_WIDTH  result beat.
- `s_tlast`  in  1  last beat of the tile.
- `m_tvalid`  out  1  packed word valid.
- `m_tready`  in  1  downstream (write master) ready.
- `m_tdata`  out  C_OUT_WIDTH  packed word; lane k at bits [k*C_IN_WIDTH +: C_IN_WIDTH].
- `m_tlast`  out  1  word holds the tile's last beat.
- `byte_count`  out  C_CNT_WIDTH  bytes handed off on m side since reset.
- `tile_done`  out  1  one-cycle pulse per completed tile.

## Operation
- State: accumulator `acc` (C_OUT_WIDTH), lane index `idx` (0..R-1), output register (`m_tdata`, `m_tlast`, `m_tvalid`).
- `s_tready = ~areset & (~m_tvalid | m_tready)`. Ready never depends on `s_tvalid`.
- Accept (`s_tvalid & s_tready`), non-completing beat (`idx != R-1` and `~s_tlast`):
  - Write lane `idx` of `acc` with `s_tdata`.
  - `idx <= idx+1`.
- Completing beat (`idx == R-1` or `s_tlast`):
  - Load `m_tdata` with `acc` with lane `idx` replaced by `s_tdata`. Lanes above `idx` are zero because `acc` is cleared on every load.
  - Load `m_tlast <= s_tlast`, `m_tvalid <= 1`.
  - Clear `acc <= 0` and `idx <= 0`.
- Output handshake (`m_tvalid & m_tready`) with no load in the same cycle: `m_tvalid <= 0`, `m_tlast <= 0`. `m_tdata` holds its value.
- Handshake and load in the same cycle: the new word replaces the old one and `m_tvalid` stays 1. No bubble, no loss.
- While `m_tvalid & ~m_tready`:
  - `m_tdata` and `m_tlast` are held stable.
  - `s_tready` is 0, so `acc` is frozen.
- Counter: on each output handshake, `byte_count <= byte_count + C_OUT_WIDTH/8`, modulo 2^C_CNT_WIDTH (wraps, no saturation).
- `tile_done`: registered; high for exactly the cycle after a handshake with `m_tlast=1`.

## Timing
- Reset values: `m_tvalid=0`, `m_tlast=0`, `m_tdata=0`, `byte_count=0`, `tile_done=0`, `s_tready=0`; `acc=0`, `idx=0`.
- First cycle after reset release: `s_tready=1`.
- Reset mid-tile discards `acc` and any pending output word; no partial word is emitted.
- Latency: completing beat accepted at cycle N gives `m_tvalid=1` at cycle N+1.
- Throughput: 1 input beat/cycle while `m_tready` stays high. A full word is produced every R accepted beats, or earlier on `s_tlast`.
- Boundary cases:
  - `s_tlast` with `idx=0`: single-lane word, lanes 1..R-1 zero.
  - `s_tlast` with `idx=R-1`: full word, no padding.
  - Consecutive tiles: the next tile starts at lane 0 of a fresh word.
- `byte_count` and `tile_done` update in the cycle after the output handshake.

## Configuration
- `GACTX_TB_PACKER_COUNT_EN`.
- Defined: byte counter and `tile_done` logic built as described.
- Undefined: counter and pulse logic omitted; `byte_count` tied to 0 and `tile_done` tied to 0. Packing and handshake behaviour is identical in both builds.

## Test plan
- Full word: 16 beats 0x00..0x0F, `s_tlast` on the last, `m_tready=1` -> one word with lane k = k, `m_tlast=1`, `byte_count=64`, `tile_done` pulse one cycle after the handshake.
- Padding: 3 beats 0xA, 0xB, 0xC with `s_tlast` on 0xC -> lanes 0..2 = A, B, C; lanes 3..15 = 0; `m_tlast=1`; `m_tvalid` rises the cycle after 0xC is accepted.
- Backpressure: 32 beats while `m_tready` toggles 1,0,0,1... -> exactly 2 words in order; `m_tdata` stable while stalled; `s_tready=0` whenever `m_tvalid & ~m_tready`; no beat lost or duplicated.
- Back-to-back tiles: tile A = 17 beats, tile B = 1 beat (0x55) ->
  - Words: A full, `m_tlast=0`; A lane0 only, `m_tlast=1`; B lane0 = 0x55, `m_tlast=1`.
  - `byte_count=192`, two `tile_done` pulses.
- Reset mid-tile: 5 beats accepted, `areset` for 1 cycle, then 16 fresh beats -> only the fresh word is output, lane 0 = first fresh beat, `byte_count=64`.
- Macro off: repeat the first scenario -> same `m_tdata`/`m_tlast`; `byte_count=0`; `tile_done` never asserted.
